// File: rtl/baud_tick_gen_prog.sv
// Runtime-programmable fractional baud tick generator: a phase accumulator
// produces the oversample tick, an oversample counter derives mid-bit and bit ticks.
module baud_tick_gen_prog #(
  parameter int          ACC_WIDTH = 24,
  parameter int          OVS       = 16,
  parameter int unsigned INC_RESET = 1030792
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sync,
  input  logic                 inc_wr,
  input  logic [ACC_WIDTH-1:0] inc_wdata,
  output logic [ACC_WIDTH-1:0] inc_value,
  output logic                 os_tick,
  output logic                 mid_tick,
  output logic                 bit_tick
);

  localparam int                   CNT_W      = $clog2(OVS);
  localparam logic [ACC_WIDTH-1:0] INC_RST_V  = ACC_WIDTH'(INC_RESET);
  localparam logic [ACC_WIDTH-1:0] ACC_ZERO   = {ACC_WIDTH{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(OVS - 1);
  localparam logic [CNT_W-1:0]     CNT_MID    = CNT_W'(OVS / 2 - 1);

  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] acc_nxt_s;
  logic [ACC_WIDTH-1:0] inc_r;
  logic [ACC_WIDTH-1:0] inc_nxt_s;
  logic [CNT_W-1:0]     os_cnt_r;
  logic [CNT_W-1:0]     os_cnt_nxt_s;
  logic                 os_tick_r;
  logic                 os_tick_nxt_s;
  logic                 mid_tick_r;
  logic                 mid_tick_nxt_s;
  logic                 bit_tick_r;
  logic                 bit_tick_nxt_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 carry_s;

  // The carry out of the widened sum is the oversample event; only the low bits are kept.
  assign sum_s   = {1'b0, acc_r} + {1'b0, inc_r};
  assign carry_s = sum_s[ACC_WIDTH];

  // Next-state for accumulator, oversample counter and ticks; sync outranks enable.
  always_comb begin
    acc_nxt_s      = acc_r;
    os_cnt_nxt_s   = os_cnt_r;
    os_tick_nxt_s  = 1'b0;
    mid_tick_nxt_s = 1'b0;
    bit_tick_nxt_s = 1'b0;
    if (sync || !enable) begin
      acc_nxt_s    = ACC_ZERO;
      os_cnt_nxt_s = CNT_ZERO;
    end else begin
      acc_nxt_s      = sum_s[ACC_WIDTH-1:0];
      os_tick_nxt_s  = carry_s;
      mid_tick_nxt_s = carry_s && (os_cnt_r == CNT_MID);
      if (carry_s) begin
        if (os_cnt_r == CNT_LAST) begin
          os_cnt_nxt_s   = CNT_ZERO;
          bit_tick_nxt_s = 1'b1;
        end else begin
          os_cnt_nxt_s   = os_cnt_r + CNT_ONE;
          bit_tick_nxt_s = 1'b0;
        end
      end else begin
        os_cnt_nxt_s = os_cnt_r;
      end
    end
  end

  // Increment register write; the addition this edge still sees the old value.
  always_comb begin
    inc_nxt_s = inc_r;
    if (inc_wr) begin
      inc_nxt_s = inc_wdata;
    end else begin
      inc_nxt_s = inc_r;
    end
  end

  // State and registered tick outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= ACC_ZERO;
      inc_r      <= INC_RST_V;
      os_cnt_r   <= CNT_ZERO;
      os_tick_r  <= 1'b0;
      mid_tick_r <= 1'b0;
      bit_tick_r <= 1'b0;
    end else begin
      acc_r      <= acc_nxt_s;
      inc_r      <= inc_nxt_s;
      os_cnt_r   <= os_cnt_nxt_s;
      os_tick_r  <= os_tick_nxt_s;
      mid_tick_r <= mid_tick_nxt_s;
      bit_tick_r <= bit_tick_nxt_s;
    end
  end

  assign inc_value = inc_r;
  assign os_tick   = os_tick_r;
  assign mid_tick  = mid_tick_r;
  assign bit_tick  = bit_tick_r;

endmodule

// File: tb/tb_baud_tick_gen_prog.sv
// Self-checking bench for baud_tick_gen_prog: unwrapped-phase reference model
// compared every cycle, plus directed scenarios with hand-computed timings.
module tb_baud_tick_gen_prog;

  localparam int          W     = 24;
  localparam int          OVS   = 16;
  localparam int unsigned INC_R = 1030792;
  localparam longint      MOD   = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         sync = 1'b0;
  logic         inc_wr = 1'b0;
  logic [W-1:0] inc_wdata = '0;
  logic [W-1:0] inc_value;
  logic         os_tick, mid_tick, bit_tick;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  baud_tick_gen_prog #(.ACC_WIDTH(W), .OVS(OVS), .INC_RESET(INC_R)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sync(sync),
    .inc_wr(inc_wr), .inc_wdata(inc_wdata), .inc_value(inc_value),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    cmp_cnt++;
    if (act != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: unwrapped phase since last clear; the k-th oversample
  // tick of a run is a bit tick when k%OVS==0 and a mid tick when k%OVS==OVS/2.
  longint ph = 0;
  longint tcnt = 0;
  longint m_inc = longint'(INC_R);
  logic   exp_os = 1'b0, exp_mid = 1'b0, exp_bit = 1'b0;
  longint nph, tn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; tcnt <= 0; m_inc <= longint'(INC_R);
      exp_os <= 1'b0; exp_mid <= 1'b0; exp_bit <= 1'b0;
    end else begin
      if (sync || !enable) begin
        ph <= 0; tcnt <= 0;
        exp_os <= 1'b0; exp_mid <= 1'b0; exp_bit <= 1'b0;
      end else begin
        nph = ph + m_inc;
        if ((nph / MOD) != (ph / MOD)) begin
          tn = tcnt + 1;
          exp_os  <= 1'b1;
          exp_bit <= (tn % OVS) == 0;
          exp_mid <= (tn % OVS) == (OVS / 2);
          tcnt <= tn;
        end else begin
          exp_os <= 1'b0; exp_mid <= 1'b0; exp_bit <= 1'b0;
        end
        ph <= nph;
      end
      if (inc_wr) m_inc <= longint'(inc_wdata);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("os_tick", os_tick, exp_os);
    chk("mid_tick", mid_tick, exp_mid);
    chk("bit_tick", bit_tick, exp_bit);
    chk("inc_value", inc_value, m_inc);
  end

  int ob_first_os, ob_second_os, ob_first_mid, ob_first_bit;
  int ob_n_os, ob_n_mid, ob_n_bit;

  // Watch n cycles; index 1 is the sample after the first edge following the call.
  task automatic observe(input int n);
    ob_first_os = 0; ob_second_os = 0; ob_first_mid = 0; ob_first_bit = 0;
    ob_n_os = 0; ob_n_mid = 0; ob_n_bit = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (os_tick) begin
        ob_n_os++;
        if (ob_first_os == 0) ob_first_os = i;
        else if (ob_second_os == 0) ob_second_os = i;
      end
      if (mid_tick) begin
        ob_n_mid++;
        if (ob_first_mid == 0) ob_first_mid = i;
      end
      if (bit_tick) begin
        ob_n_bit++;
        if (ob_first_bit == 0) ob_first_bit = i;
      end
    end
  endtask

  task automatic check_restart(input string tag);
    observe(130);
    chk({tag, "_first_os"}, ob_first_os, 4);
    chk({tag, "_second_os"}, ob_second_os, 8);
    chk({tag, "_first_mid"}, ob_first_mid, 32);
    chk({tag, "_first_bit"}, ob_first_bit, 64);
    chk({tag, "_n_os"}, ob_n_os, 32);
    chk({tag, "_n_bit"}, ob_n_bit, 2);
    chk({tag, "_n_mid"}, ob_n_mid, 2);
  endtask

  initial begin
    // 1. reset values
    repeat (3) @(negedge clk);
    chk("rst_inc_value", inc_value, 1030792);
    chk("rst_os", os_tick, 0);
    chk("rst_mid", mid_tick, 0);
    chk("rst_bit", bit_tick, 0);
    rst_n = 1'b1;

    // 2. inc = 2^22 written while disabled, then enable
    @(negedge clk);
    inc_wr = 1'b1; inc_wdata = 24'd4194304;
    observe(1);
    chk("wr_while_disabled", inc_value, 4194304);
    inc_wr = 1'b0; enable = 1'b1;
    check_restart("s2");

    // 3. sync pulse at cycle 40 of a fresh run
    enable = 1'b0; observe(1);
    enable = 1'b1; observe(39);
    sync = 1'b1; observe(1);
    chk("s3_sync_os", ob_n_os, 0);
    sync = 1'b0;
    observe(70);
    chk("s3_first_os", ob_first_os, 4);
    chk("s3_first_mid", ob_first_mid, 32);
    chk("s3_first_bit", ob_first_bit, 64);

    // 4. increment write on a counting edge uses the old value on that edge
    enable = 1'b0; observe(1);
    enable = 1'b1; observe(6);
    inc_wr = 1'b1; inc_wdata = 24'd8388608;
    @(negedge clk);
    chk("s4_wr_edge_os", os_tick, 0);
    chk("s4_inc_value", inc_value, 8388608);
    inc_wr = 1'b0;
    observe(10);
    chk("s4_first_os", ob_first_os, 1);
    chk("s4_second_os", ob_second_os, 3);
    chk("s4_n_os", ob_n_os, 5);

    // 5. enable low for 10 cycles mid-bit, then restart; then inc = 0
    enable = 1'b0; inc_wr = 1'b1; inc_wdata = 24'd4194304;
    observe(1);
    inc_wr = 1'b0; enable = 1'b1;
    observe(40);
    enable = 1'b0;
    observe(10);
    chk("s5_low_os", ob_n_os, 0);
    chk("s5_low_mid", ob_n_mid, 0);
    chk("s5_low_bit", ob_n_bit, 0);
    enable = 1'b1;
    check_restart("s5");
    inc_wr = 1'b1; inc_wdata = 24'd0;
    observe(1);
    inc_wr = 1'b0;
    observe(1000);
    chk("s5_zero_inc_os", ob_n_os, 0);
    chk("s5_zero_inc_bit", ob_n_bit, 0);

    // reset mid-operation restores the reset increment immediately
    rst_n = 1'b0; enable = 1'b0;
    #1;
    chk("midrst_inc_value", inc_value, 1030792);
    chk("midrst_os", os_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 6. default increment, long run of 50000 enabled edges
    enable = 1'b1;
    observe(50000);
    chk("s6_n_os", ob_n_os, 3071);
    chk("s6_n_bit", ob_n_bit, 191);
    chk("s6_n_mid", ob_n_mid, 192);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen_prog.md
Name: baud_tick_gen_prog

Overview:
- Runtime-programmable fractional baud tick generator; successor to the fixed-parameter tick generator used by the UART TX/RX paths.
- Phase accumulator with a writable increment register produces an oversample tick.
- A built-in oversample counter derives a per-bit tick and a mid-bit sampling tick.
- A sync input re-phases everything on an RX start-bit edge.

Parameters:
- ACC_WIDTH, 24, fractional accumulator width; oversample tick rate = f_clk * inc / 2^ACC_WIDTH.
- OVS, 16, oversampling factor (os_ticks per bit); legal range 2..256.
- INC_RESET, 1030792, increment loaded at reset (30 MHz clk, 115200 baud x16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  count enable; low holds the generator cleared.
- sync  in  1  re-phase strobe; clears accumulator and oversample counter.
- inc_wr  in  1  write strobe for the increment register.
- inc_wdata  in  ACC_WIDTH  new increment value.
- inc_value  out  ACC_WIDTH  current increment register contents.
- os_tick  out  1  one-cycle pulse at oversample rate.
- mid_tick  out  1  one-cycle pulse at mid-bit (os_cnt == OVS/2-1 on tick).
- bit_tick  out  1  one-cycle pulse at bit rate (os_cnt == OVS-1 on tick).

Behaviour:
- State:
  - acc[ACC_WIDTH-1:0]
  - inc_reg[ACC_WIDTH-1:0]
  - os_cnt[clog2(OVS)-1:0]
  - registered os_tick, mid_tick, bit_tick
- Reset (rst_n low, async):
  - acc=0, os_cnt=0, inc_reg=INC_RESET.
  - All ticks 0.
  - inc_value=INC_RESET immediately.
- Per rising edge, priority sync > !enable > count:
  - sync=1: acc<=0, os_cnt<=0, all ticks<=0. Counting resumes on the next edge if enable=1.
  - enable=0: acc<=0, os_cnt<=0, all ticks<=0.
  - count: {carry, acc} <= acc + inc_reg, as an (ACC_WIDTH+1)-bit sum; the upper bit is the carry and is not stored.
- Tick generation on a counting edge:
  - os_tick<=carry.
  - If carry and os_cnt==OVS-1: os_cnt<=0, bit_tick<=1.
  - Else if carry: os_cnt<=os_cnt+1, bit_tick<=0.
  - mid_tick<=carry && (os_cnt==OVS/2-1), using integer division.
  - No carry: os_cnt holds, all ticks<=0.
- Latency: ticks are registered and visible the cycle after the edge on which the carry is computed. Ticks are never asserted for more than 1 consecutive cycle unless inc_reg >= 2^(ACC_WIDTH-1).
- bit_tick and os_tick coincide. mid_tick and os_tick coincide. mid_tick and bit_tick never coincide for OVS >= 2.
- Increment register:
  - inc_wr=1 loads inc_wdata on the edge.
  - The addition on that same edge uses the old inc_reg; the new value is effective from the next edge.
  - inc_wr is independent of enable and sync.
  - inc_value = inc_reg, continuously.
- Boundaries:
  - inc_reg=0: no ticks ever.
  - inc_reg=2^ACC_WIDTH-1: os_tick on all counting edges but one per 2^ACC_WIDTH.
  - acc wraps modulo 2^ACC_WIDTH; fractional remainder is retained, so long-run tick count = floor(N*inc/2^ACC_WIDTH) after N counting edges from zero.
- Reset mid-operation: all state returns to reset values immediately, including inc_reg (a previously written value is lost).

Test Plan:
1. Reset with ACC_WIDTH=24 -> inc_value=1030792, os_tick/mid_tick/bit_tick=0.
2. Enable with inc=4194304 (2^22), OVS=16 -> os_tick first high after the 4th enabled edge, then every 4 cycles; mid_tick first at cycle 32; bit_tick at cycle 64, then every 64.
3. Same setup, pulse sync at cycle 40 -> all ticks 0 that cycle; next os_tick 4 edges after sync drops; next mid_tick 32 and next bit_tick 64 cycles after sync.
4. Mid-run, write inc=8388608 on the same edge as a counting addition -> that edge still uses 4194304; subsequent os_tick period is 2 cycles; inc_value reads 8388608 from the next cycle.
5. enable low for 10 cycles mid-bit, then high -> ticks stay 0 while low; the restart timing matches scenario 2 exactly. Also write inc=0 -> no ticks over 1000 cycles.
6. Default inc, enable held for 1,000,000 cycles -> exactly 61439 os_ticks, 3839 bit_ticks (floor(61439/16)), and mid_tick count 3840.
